ntt_bram_sched: RTL and testbench

// - Sequences one in-place NTT/INTT over a single coefficient BRAM.
// - The BRAM has 1 write port, 1 read port, 1-cycle read latency, and returns old data on a same-cycle read/write collision.
// - Each stage issues one BRAM read per cycle, as butterfly operand pairs (a then b), plus a twiddle ROM index.
// - Write-back addresses are the read addresses delayed to match the butterfly pipeline.
// - Sits between the top-level NTT control and the BRAM, twiddle ROM and butterfly unit.

---
 rtl/ntt_pkg.sv | 24 ++
 rtl/ntt_bram_sched_wb_delay.sv | 43 ++++
 rtl/ntt_bram_sched.sv | 177 +++++++++++++++++
 tb/tb_ntt_bram_sched.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared constants, FSM encoding and helpers for the NTT BRAM scheduler.
package ntt_pkg;

  // Default transform size and butterfly latency.
  localparam int unsigned HlenDefault  = 8;
  localparam int unsigned BflatDefault = 4;

  // Depth of the write-back delay: one cycle of BRAM read latency plus the butterfly.
  function automatic int unsigned wb_depth(int unsigned bflat);
    return 1 + bflat;
  endfunction

  localparam int unsigned N   = 1 << HlenDefault;
  localparam int unsigned STW = $clog2(HlenDefault);
  localparam int unsigned D   = wb_depth(BflatDefault);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/ntt_bram_sched_wb_delay.sv
// Write-back delay line: shifts (valid, addr) through Depth stages.
// empty_o is high when nothing is queued behind the entry presented on the outputs,
// i.e. the write leaving this cycle (if any) is the last outstanding one.
module ntt_wb_delay
  import ntt_pkg::*;
#(
  parameter int unsigned Depth = D,
  parameter int unsigned AddrW = 8
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             valid_i,
  input  logic [AddrW-1:0] addr_i,
  output logic             valid_o,
  output logic [AddrW-1:0] addr_o,
  output logic             empty_o
);

  logic [Depth-1:0]            vld_q, vld_d;
  logic [Depth-1:0][AddrW-1:0] adr_q, adr_d;

  // Shift one stage per cycle; stage 0 takes the new read.
  always_comb begin
    vld_d = {vld_q[Depth-2:0], valid_i};
    adr_d = {adr_q[Depth-2:0], addr_i};
  end

  // Synchronous clear drops every in-flight write-back.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      vld_q <= '0;
      adr_q <= '0;
    end else begin
      vld_q <= vld_d;
      adr_q <= adr_d;
    end
  end

  assign valid_o = vld_q[Depth-1];
  assign addr_o  = adr_q[Depth-1];
  assign empty_o = ~|vld_q[Depth-2:0];

endmodule

// File: rtl/ntt_bram_sched.sv
// In-place NTT/INTT scheduler for a single-port-pair coefficient BRAM.
// Issues one read per cycle (a then b operand), the twiddle index, and a delayed write-back.
module ntt_bram_sched
  import ntt_pkg::*;
#(
  parameter int unsigned HLEN  = HlenDefault,
  parameter int unsigned BFLAT = BflatDefault
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    intt,
  output logic                    busy,
  output logic                    done,
  output logic [$clog2(HLEN)-1:0] stage,
  output logic                    bf_mode,
  output logic                    ren,
  output logic [HLEN-1:0]         raddr,
  output logic                    rd_b,
  output logic [HLEN-1:0]         tw_addr,
  output logic                    wen,
  output logic [HLEN-1:0]         waddr
);

  localparam int unsigned NumC = 1 << HLEN;
  localparam int unsigned StW  = $clog2(HLEN);
  localparam int unsigned Dly  = wb_depth(BFLAT);

  // Operand address for butterfly b of stage s; ph selects the b operand.
  function automatic logic [HLEN-1:0] rd_addr(logic inv, logic [StW-1:0] s,
                                              logic [HLEN-2:0] b, logic ph);
    int unsigned lg, len, g, o, a;
    lg  = inv ? 32'(s) : (HLEN - 1) - 32'(s);
    len = 32'd1 << lg;
    g   = 32'(b) >> lg;
    o   = 32'(b) & (len - 1);
    a   = ((g << lg) << 1) + o;
    return HLEN'(ph ? a + len : a);
  endfunction

  // Twiddle ROM index; depends only on the butterfly group, so a and b reads share it.
  function automatic logic [HLEN-1:0] tw_idx(logic inv, logic [StW-1:0] s, logic [HLEN-2:0] b);
    int unsigned lg, g;
    lg = inv ? 32'(s) : (HLEN - 1) - 32'(s);
    g  = 32'(b) >> lg;
    return inv ? HLEN'((NumC >> s) - 1 - g) : HLEN'((32'd1 << s) + g);
  endfunction

  state_e          state_q, state_d;
  logic [StW-1:0]  stage_q, stage_d;
  logic [HLEN-2:0] bfly_q, bfly_d;
  logic            ph_q, ph_d;
  logic            mode_q, mode_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            ren_q, ren_d;
  logic [HLEN-1:0] raddr_q, raddr_d;
  logic            rdb_q, rdb_d;
  logic [HLEN-1:0] tw_q, tw_d;
  logic            wb_empty;

  // Next-state: the registered outputs describe the read issued in the coming cycle.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    bfly_d  = bfly_q;
    ph_d    = ph_q;
    mode_d  = mode_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ren_d   = 1'b0;
    raddr_d = raddr_q;
    rdb_d   = rdb_q;
    tw_d    = tw_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          stage_d = '0;
          bfly_d  = '0;
          ph_d    = 1'b0;
          mode_d  = intt;
          busy_d  = 1'b1;
          ren_d   = 1'b1;
        end
      end
      StRun: begin
        if ((&bfly_q) && ph_q) begin
          state_d = StDrain;
        end else begin
          ph_d  = ~ph_q;
          ren_d = 1'b1;
          if (ph_q) bfly_d = bfly_q + 1'b1;
        end
      end
      StDrain: begin
        // Next stage may start only once the final write-back of this stage is on the port.
        if (wb_empty) begin
          if (stage_q == StW'(HLEN - 1)) begin
            state_d = StDone;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = StRun;
            stage_d = stage_q + 1'b1;
            bfly_d  = '0;
            ph_d    = 1'b0;
            ren_d   = 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    if (ren_d) begin
      raddr_d = rd_addr(mode_d, stage_d, bfly_d, ph_d);
      rdb_d   = ph_d;
      tw_d    = tw_idx(mode_d, stage_d, bfly_d);
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      stage_q <= '0;
      bfly_q  <= '0;
      ph_q    <= 1'b0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ren_q   <= 1'b0;
      raddr_q <= '0;
      rdb_q   <= 1'b0;
      tw_q    <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      bfly_q  <= bfly_d;
      ph_q    <= ph_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ren_q   <= ren_d;
      raddr_q <= raddr_d;
      rdb_q   <= rdb_d;
      tw_q    <= tw_d;
    end
  end

  ntt_wb_delay #(
    .Depth(Dly),
    .AddrW(HLEN)
  ) u_wb_delay (
    .clk_i  (clk),
    .clr_i  (reset),
    .valid_i(ren_q),
    .addr_i (raddr_q),
    .valid_o(wen),
    .addr_o (waddr),
    .empty_o(wb_empty)
  );

  assign busy    = busy_q;
  assign done    = done_q;
  assign stage   = stage_q;
  assign bf_mode = mode_q;
  assign ren     = ren_q;
  assign raddr   = raddr_q;
  assign rd_b    = rdb_q;
  assign tw_addr = tw_q;

endmodule

// File: tb/tb_ntt_bram_sched.sv
// Bench for ntt_bram_sched: cycle-exact comparison against an arithmetic model of the schedule.
module tb_ntt_bram_sched;

  localparam int HLEN     = 8;
  localparam int BFLAT    = 4;
  localparam int N        = 1 << HLEN;
  localparam int P        = N + BFLAT + 1;
  localparam int DLY      = BFLAT + 1;
  localparam int DONE_CYC = 1 + HLEN * P;

  logic            clk;
  logic            reset;
  logic            start;
  logic            intt;
  logic            busy;
  logic            done;
  logic [2:0]      stage;
  logic            bf_mode;
  logic            ren;
  logic [HLEN-1:0] raddr;
  logic            rd_b;
  logic [HLEN-1:0] tw_addr;
  logic            wen;
  logic [HLEN-1:0] waddr;

  int checks;
  int errors;

  ntt_bram_sched #(
    .HLEN (HLEN),
    .BFLAT(BFLAT)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .intt   (intt),
    .busy   (busy),
    .done   (done),
    .stage  (stage),
    .bf_mode(bf_mode),
    .ren    (ren),
    .raddr  (raddr),
    .rd_b   (rd_b),
    .tw_addr(tw_addr),
    .wen    (wen),
    .waddr  (waddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read expected in cycle c of a transform whose start was accepted at cycle 0.
  function automatic void model_rd(input int inv, input int c, output bit v, output int stg,
                                   output int addr, output int bsel, output int tw);
    int t, r, b, len, g, a;
    v = 0; stg = 0; addr = 0; bsel = 0; tw = 0;
    t = c - 1;
    if (t < 0 || t >= HLEN * P) return;
    stg = t / P;
    r   = t % P;
    if (r >= N) return;
    v    = 1;
    b    = r / 2;
    bsel = r % 2;
    len  = inv ? (1 << stg) : (N >> (stg + 1));
    g    = b / len;
    a    = 2 * g * len + (b % len);
    addr = bsel ? a + len : a;
    tw   = inv ? (N >> stg) - 1 - g : (1 << stg) + g;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({busy, done, ren, wen, rd_b, bf_mode, stage, raddr, tw_addr, waddr} !== '0) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d busy=%0b ren=%0b wen=%0b raddr=%0d tw=%0d exp all 0",
                 i, busy, ren, wen, raddr, tw_addr);
      end
    end
    reset = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || ren !== 1'b0) begin
        errors++;
        $display("FAIL reset_start_ignored busy=%0b ren=%0b exp 0 0", busy, ren);
      end
    end
  endtask

  task automatic test_transform(input bit inv, input int xstart, input bit start_in_done);
    bit v, vw;
    int s, a, bs, tw, sw, aw, bw, tww;
    int writes;
    writes = 0;
    @(negedge clk);
    intt  = inv;
    start = 1'b1;
    for (int c = 1; c <= DONE_CYC + 1; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      intt  = 1'($urandom_range(0, 1));
      model_rd(int'(inv), c, v, s, a, bs, tw);
      model_rd(int'(inv), c - DLY, vw, sw, aw, bw, tww);
      checks++;
      if (busy !== 1'(c < DONE_CYC)) begin
        errors++;
        $display("FAIL busy c=%0d got=%0b exp=%0b", c, busy, c < DONE_CYC);
      end
      checks++;
      if (done !== 1'(c == DONE_CYC)) begin
        errors++;
        $display("FAIL done c=%0d got=%0b exp=%0b", c, done, c == DONE_CYC);
      end
      checks++;
      if (ren !== v) begin
        errors++;
        $display("FAIL ren c=%0d got=%0b exp=%0b", c, ren, v);
      end
      if (v) begin
        checks++;
        if (raddr !== HLEN'(a) || rd_b !== 1'(bs) || tw_addr !== HLEN'(tw) || stage !== 3'(s)) begin
          errors++;
          $display("FAIL read c=%0d got addr=%0d b=%0b tw=%0d s=%0d exp addr=%0d b=%0d tw=%0d s=%0d",
                   c, raddr, rd_b, tw_addr, stage, a, bs, tw, s);
        end
      end
      checks++;
      if (wen !== vw) begin
        errors++;
        $display("FAIL wen c=%0d got=%0b exp=%0b", c, wen, vw);
      end
      if (vw) begin
        checks++;
        if (waddr !== HLEN'(aw)) begin
          errors++;
          $display("FAIL waddr c=%0d got=%0d exp=%0d", c, waddr, aw);
        end
      end
      if (c < DONE_CYC) begin
        checks++;
        if (bf_mode !== inv) begin
          errors++;
          $display("FAIL bf_mode c=%0d got=%0b exp=%0b", c, bf_mode, inv);
        end
      end
      if (wen === 1'b1) writes++;
      if (c == xstart) start = 1'b1;
      if (start_in_done && c == DONE_CYC) start = 1'b1;
    end
    start = 1'b0;
    checks++;
    if (writes != HLEN * N) begin
      errors++;
      $display("FAIL write_count got=%0d exp=%0d", writes, HLEN * N);
    end
  endtask

  task automatic test_mid_reset(input bit inv, input int rc);
    bit v;
    int s, a, bs, tw;
    @(negedge clk);
    intt  = inv;
    start = 1'b1;
    for (int c = 1; c <= rc; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      model_rd(int'(inv), c, v, s, a, bs, tw);
      checks++;
      if (ren !== v || (v && raddr !== HLEN'(a))) begin
        errors++;
        $display("FAIL pre_reset_read c=%0d ren=%0b addr=%0d exp ren=%0b addr=%0d",
                 c, ren, raddr, v, a);
      end
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if ({busy, done, ren, wen, rd_b, bf_mode, stage, raddr, tw_addr, waddr} !== '0) begin
      errors++;
      $display("FAIL mid_reset rc=%0d busy=%0b wen=%0b ren=%0b waddr=%0d exp all 0",
               rc, busy, wen, ren, waddr);
    end
    for (int i = 0; i < DLY + 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || ren !== 1'b0 || wen !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_idle i=%0d busy=%0b ren=%0b wen=%0b exp 0 0 0",
                 i, busy, ren, wen);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    start  = 1'b0;
    intt   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_transform(1'b0, 500, 1'b0);
    test_transform(1'b1, int'($urandom_range(2, DONE_CYC - 2)), 1'b1);
    // Back-to-back: starts in the first idle cycle after the previous transform.
    test_transform(1'($urandom_range(0, 1)), int'($urandom_range(2, DONE_CYC - 2)), 1'b0);
    test_mid_reset(1'b0, 100);
    test_transform(1'b0, 500, 1'b0);
    test_mid_reset(1'($urandom_range(0, 1)), int'($urandom_range(2, DONE_CYC - 2)));
    test_transform(1'b1, 500, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
